// File: rtl/pcie_rx_dispatch_pkg.sv
// Shared types for the host-to-FPGA rx stream dispatcher: FSM states and the
// header word layout (dest in the top byte, length in the low bits).
package pcie_rx_dispatch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PAYLOAD = 2'd1,
        ST_DRAIN   = 2'd2,
        ST_CHECK   = 2'd3
    } state_e;

    localparam int DEST_LSB = 24;
    localparam int DEST_W   = 8;

    typedef struct packed {
        logic [DEST_W-1:0]   dest;
        logic [DEST_LSB-1:0] len_f;
    } hdr_t;

endpackage

// File: rtl/pcie_rx_csum.sv
// XOR checksum over popped payload words plus trailer compare; only built when
// PCIE_RX_DISPATCH_CHECKSUM_EN is defined.
`ifdef PCIE_RX_DISPATCH_CHECKSUM_EN
module pcie_rx_csum #(
    parameter int WORD_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              clr_i,
    input  logic              acc_i,
    input  logic              chk_i,
    input  logic [WORD_W-1:0] data_i,
    input  logic              err_clear_i,
    output logic              err_csum_o,
    output logic              csum_bad_o
);

    logic [WORD_W-1:0] acc_q, acc_d;
    logic              err_q, err_d;
    logic              bad_q, bad_d;

    always_comb begin
        acc_d = acc_q;
        if (clr_i) begin
            acc_d = '0;
        end else if (acc_i) begin
            acc_d = acc_q ^ data_i;
        end
        bad_d = chk_i && (data_i != acc_q);
        err_d = err_q;
        if (err_clear_i) err_d = 1'b0;
        if (bad_d)       err_d = 1'b1;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            acc_q <= '0;
            err_q <= 1'b0;
            bad_q <= 1'b0;
        end else begin
            acc_q <= acc_d;
            err_q <= err_d;
            bad_q <= bad_d;
        end
    end

    assign err_csum_o = err_q;
    assign csum_bad_o = bad_q;

endmodule
`endif

// File: rtl/pcie_rx_dispatch.sv
// Single reader of the rx FIFO: parses header words and routes payload words to
// one of NDEST destination FIFOs. Optional trailer checksum: PCIE_RX_DISPATCH_CHECKSUM_EN.
module pcie_rx_dispatch
    import pcie_rx_dispatch_pkg::*;
#(
    parameter int NDEST  = 4,
    parameter int WORD_W = 32,
    parameter int LEN_W  = 24
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rx_empty,
    input  logic [WORD_W-1:0] rx_q,
    output logic              rx_rdreq,
    input  logic [NDEST-1:0]  dst_full,
    output logic [NDEST-1:0]  dst_wrreq,
    output logic [WORD_W-1:0] dst_d,
    input  logic              err_clear,
`ifdef PCIE_RX_DISPATCH_CHECKSUM_EN
    output logic              err_csum,
    output logic              csum_bad,
`endif
    output logic              busy,
    output logic              err_bad_dest,
    output logic [15:0]       pkt_count
);

    localparam int DIDX_W = (NDEST > 1) ? $clog2(NDEST) : 1;

    state_e             state_q, state_d;
    logic [LEN_W-1:0]   rem_q, rem_d;
    logic [DIDX_W-1:0]  dest_q, dest_d;
    logic               err_q, err_d;
    logic [15:0]        pkt_q, pkt_d;
    logic               pop;
    logic               last_pop;
    logic [NDEST-1:0]   wr;
    hdr_t               hdr;
    logic [LEN_W-1:0]   hdr_len;
    logic               hdr_bad;

    assign hdr     = rx_q[DEST_LSB+DEST_W-1:0];
    assign hdr_len = hdr.len_f[LEN_W-1:0];
    assign hdr_bad = int'(hdr.dest) >= NDEST;

    always_comb begin
        state_d  = state_q;
        rem_d    = rem_q;
        dest_d   = dest_q;
        err_d    = err_q;
        pkt_d    = pkt_q;
        pop      = 1'b0;
        last_pop = 1'b0;
        wr       = '0;
        if (err_clear) err_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (!rx_empty) begin
                    pop    = 1'b1;
                    rem_d  = hdr_len;
                    dest_d = hdr.dest[DIDX_W-1:0];
                    if (hdr_bad) err_d = 1'b1;
                    if (hdr_len == '0) begin
                        last_pop = 1'b1;
                    end else if (hdr_bad) begin
                        state_d = ST_DRAIN;
                    end else begin
                        state_d = ST_PAYLOAD;
                    end
                end
            end
            ST_PAYLOAD: begin
                // Write strobe is the pop itself, so a full destination simply holds the word in rx
                if (!rx_empty && !dst_full[dest_q]) begin
                    pop        = 1'b1;
                    wr[dest_q] = 1'b1;
                    rem_d      = rem_q - LEN_W'(1);
                    last_pop   = (rem_q == LEN_W'(1));
                end
            end
            ST_DRAIN: begin
                if (!rx_empty) begin
                    pop      = 1'b1;
                    rem_d    = rem_q - LEN_W'(1);
                    last_pop = (rem_q == LEN_W'(1));
                end
            end
`ifdef PCIE_RX_DISPATCH_CHECKSUM_EN
            ST_CHECK: begin
                if (!rx_empty) begin
                    pop     = 1'b1;
                    pkt_d   = pkt_q + 16'd1;
                    state_d = ST_IDLE;
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase

        if (last_pop) begin
`ifdef PCIE_RX_DISPATCH_CHECKSUM_EN
            state_d = ST_CHECK;
`else
            state_d = ST_IDLE;
            pkt_d   = pkt_q + 16'd1;
`endif
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            rem_q   <= '0;
            dest_q  <= '0;
            err_q   <= 1'b0;
            pkt_q   <= '0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            dest_q  <= dest_d;
            err_q   <= err_d;
            pkt_q   <= pkt_d;
        end
    end

    // Strobes and data are combinational from rx_q, so gate them with the async reset too
    assign rx_rdreq     = pop && !reset;
    assign dst_wrreq    = wr & {NDEST{!reset}};
    assign dst_d        = reset ? '0 : rx_q;
    assign busy         = (state_q != ST_IDLE);
    assign err_bad_dest = err_q;
    assign pkt_count    = pkt_q;

`ifdef PCIE_RX_DISPATCH_CHECKSUM_EN
    logic csum_clr, csum_acc, csum_chk;

    assign csum_clr = pop && (state_q == ST_IDLE);
    assign csum_acc = pop && ((state_q == ST_PAYLOAD) || (state_q == ST_DRAIN));
    assign csum_chk = pop && (state_q == ST_CHECK);

    pcie_rx_csum #(
        .WORD_W (WORD_W)
    ) u_csum (
        .clk_i       (clk),
        .rst_i       (reset),
        .clr_i       (csum_clr),
        .acc_i       (csum_acc),
        .chk_i       (csum_chk),
        .data_i      (rx_q),
        .err_clear_i (err_clear),
        .err_csum_o  (err_csum),
        .csum_bad_o  (csum_bad)
    );
`endif

endmodule

// File: tb/tb_pcie_rx_dispatch.sv
// Bench for pcie_rx_dispatch (default build): show-ahead rx FIFO model, write
// scoreboard, packet vector table and hand-written multi-cycle sequences.
module tb_pcie_rx_dispatch;

    localparam int NDEST = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        rx_empty;
    logic [31:0] rx_q;
    logic        rx_rdreq;
    logic [3:0]  dst_full;
    logic [3:0]  dst_wrreq;
    logic [31:0] dst_d;
    logic        err_clear;
    logic        busy;
    logic        err_bad_dest;
    logic [15:0] pkt_count;

    always #5 clk = ~clk;

    pcie_rx_dispatch #(
        .NDEST  (NDEST),
        .WORD_W (32),
        .LEN_W  (24)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .rx_empty     (rx_empty),
        .rx_q         (rx_q),
        .rx_rdreq     (rx_rdreq),
        .dst_full     (dst_full),
        .dst_wrreq    (dst_wrreq),
        .dst_d        (dst_d),
        .err_clear    (err_clear),
        .busy         (busy),
        .err_bad_dest (err_bad_dest),
        .pkt_count    (pkt_count)
    );

    typedef struct {
        int          dest;
        logic [31:0] data;
    } wr_t;

    typedef struct {
        logic [31:0] hdr;
        int          n;
        logic [31:0] base;
        logic        exp_err;
    } vec_t;

    wr_t         sb[$];
    logic [31:0] fifo[$];
    wr_t         mon_e;
    logic [31:0] pop_junk;
    logic        pop_pend = 1'b0;
    int          n_cmp = 0;
    int          n_bad = 0;
    int          exp_pkt = 0;
    int          base_pkt;
    vec_t        vt[5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic refresh();
        rx_empty = (fifo.size() == 0);
        rx_q     = rx_empty ? 32'h0 : fifo[0];
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_pkt(input logic [31:0] hdr, input int n, input logic [31:0] base);
        logic [31:0] w;
        wr_t         e;
        fifo.push_back(hdr);
        for (int i = 0; i < n; i++) begin
            w = base + 32'(i);
            fifo.push_back(w);
            if (int'(hdr[31:24]) < NDEST) begin
                e.dest = int'(hdr[31:24]);
                e.data = w;
                sb.push_back(e);
            end
        end
        refresh();
    endtask

    task automatic wait_idle(input string name);
        logic done;
        done = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (fifo.size() == 0 && !busy && !rx_rdreq) begin
                done = 1'b1;
                break;
            end
        end
        chk(name, 32'(done), 32'd1);
    endtask

    // Output monitor: every destination write must match the scoreboard head
    always @(negedge clk) begin
        pop_pend = rx_rdreq;
        if (dst_wrreq != 4'b0) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_write: wrreq=%b data=0x%0h, no write expected", dst_wrreq, dst_d);
            end else begin
                mon_e = sb.pop_front();
                chk("wr_dest", 32'(dst_wrreq), 32'(1) << mon_e.dest);
                chk("wr_data", dst_d, mon_e.data);
            end
        end
    end

    // Show-ahead rx FIFO: pop commits just after the edge that consumed the head
    always @(posedge clk) begin
        #1;
        if (pop_pend && fifo.size() > 0) pop_junk = fifo.pop_front();
        refresh();
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        vt[0] = '{32'h03000004, 4, 32'h300, 1'b0};
        vt[1] = '{32'h02000003, 3, 32'h200, 1'b0};
        vt[2] = '{32'h07000002, 2, 32'h700, 1'b1};
        vt[3] = '{32'h00000001, 1, 32'h100, 1'b1};
        vt[4] = '{32'h04000001, 1, 32'h400, 1'b1};

        reset     = 1'b1;
        err_clear = 1'b0;
        dst_full  = 4'b0;
        fifo.push_back(32'hDEADBEEF);
        refresh();
        repeat (2) @(negedge clk);
        chk("rst_rdreq", 32'(rx_rdreq), 32'd0);
        chk("rst_wrreq", 32'(dst_wrreq), 32'd0);
        chk("rst_dst_d", dst_d, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_err", 32'(err_bad_dest), 32'd0);
        chk("rst_pkt", 32'(pkt_count), 32'd0);
        @(posedge clk);
        #1;
        fifo.delete();
        refresh();
        reset = 1'b0;

        // Three words to dest 1, no backpressure: exact cycle timing
        tick();
        push_pkt(32'h01000003, 3, 32'hA);
        exp_pkt++;
        @(negedge clk);
        chk("s1_hdr_pop", 32'(rx_rdreq), 32'd1);
        chk("s1_hdr_busy", 32'(busy), 32'd0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("s1_wrreq", 32'(dst_wrreq), 32'h2);
            chk("s1_data", dst_d, 32'hA + 32'(k));
            chk("s1_busy", 32'(busy), 32'd1);
        end
        @(negedge clk);
        chk("s1_busy_drop", 32'(busy), 32'd0);
        chk("s1_pkt", 32'(pkt_count), 32'(exp_pkt));

        // Same packet with dest 1 full for 5 cycles after the first word
        tick();
        push_pkt(32'h01000003, 3, 32'h11);
        exp_pkt++;
        @(negedge clk);
        @(negedge clk);
        chk("s2_first_wr", 32'(dst_wrreq), 32'h2);
        @(posedge clk);
        #1;
        dst_full = 4'b0010;
        repeat (5) begin
            @(negedge clk);
            chk("s2_stall_rdreq", 32'(rx_rdreq), 32'd0);
            chk("s2_stall_wrreq", 32'(dst_wrreq), 32'd0);
        end
        @(posedge clk);
        #1;
        dst_full = 4'b0;
        wait_idle("s2_idle");
        chk("s2_pkt", 32'(pkt_count), 32'(exp_pkt));
        chk("s2_sb_empty", 32'(sb.size()), 32'd0);

        for (int i = 0; i < 5; i++) begin
            tick();
            push_pkt(vt[i].hdr, vt[i].n, vt[i].base);
            exp_pkt++;
            wait_idle("tbl_idle");
            chk("tbl_pkt", 32'(pkt_count), 32'(exp_pkt));
            chk("tbl_err", 32'(err_bad_dest), 32'(vt[i].exp_err));
            chk("tbl_sb_empty", 32'(sb.size()), 32'd0);
        end

        tick();
        err_clear = 1'b1;
        tick();
        err_clear = 1'b0;
        @(negedge clk);
        chk("clr_err", 32'(err_bad_dest), 32'd0);

        // Bad-dest header popped in the same cycle err_clear is high: set wins
        tick();
        push_pkt(32'hFF000001, 1, 32'h9);
        exp_pkt++;
        err_clear = 1'b1;
        @(negedge clk);
        chk("sw_hdr_pop", 32'(rx_rdreq), 32'd1);
        tick();
        err_clear = 1'b0;
        @(negedge clk);
        chk("sw_err", 32'(err_bad_dest), 32'd1);
        wait_idle("sw_idle");
        chk("sw_pkt", 32'(pkt_count), 32'(exp_pkt));

        // Zero-length header immediately followed by a one-word packet
        tick();
        base_pkt = exp_pkt;
        push_pkt(32'h02000000, 0, 32'h0);
        push_pkt(32'h00000001, 1, 32'h55);
        @(negedge clk);
        chk("b2b_hdr0_pop", 32'(rx_rdreq), 32'd1);
        @(negedge clk);
        chk("b2b_pkt1", 32'(pkt_count), 32'(base_pkt + 1));
        chk("b2b_hdr1_pop", 32'(rx_rdreq), 32'd1);
        chk("b2b_no_wr", 32'(dst_wrreq), 32'd0);
        @(negedge clk);
        chk("b2b_wrreq", 32'(dst_wrreq), 32'h1);
        chk("b2b_data", dst_d, 32'h55);
        @(negedge clk);
        chk("b2b_pkt2", 32'(pkt_count), 32'(base_pkt + 2));
        chk("b2b_busy", 32'(busy), 32'd0);
        exp_pkt += 2;

        // Reset with two of four payload words still in the FIFO
        tick();
        push_pkt(32'h01000004, 4, 32'hC0);
        repeat (3) @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk("mid_rst_rdreq", 32'(rx_rdreq), 32'd0);
        chk("mid_rst_wrreq", 32'(dst_wrreq), 32'd0);
        chk("mid_rst_dst_d", dst_d, 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_err", 32'(err_bad_dest), 32'd0);
        chk("mid_rst_pkt", 32'(pkt_count), 32'd0);
        fifo.delete();
        sb.delete();
        refresh();
        @(posedge clk);
        #1;
        reset   = 1'b0;
        exp_pkt = 0;

        tick();
        push_pkt(32'h02000002, 2, 32'hE0);
        exp_pkt++;
        wait_idle("post_rst_idle");
        chk("post_rst_pkt", 32'(pkt_count), 32'(exp_pkt));
        chk("post_rst_sb_empty", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pcie_rx_dispatch.md
Name: pcie_rx_dispatch

Overview:
- Sequences the host-to-FPGA 32-bit PCIe stream: pops framed packets from the rx FIFO and routes payload words to one of NDEST destination FIFOs (weights, inputs, instructions, ...).
- Sits between the rx side of the PCIe DMA wrapper and the accelerator load paths.
- Is the single reader of the rx FIFO.
- Respects per-destination backpressure and discards packets addressed to nonexistent destinations.

Parameters:
- NDEST, 4, number of destination FIFOs (1..256).
- WORD_W, 32, stream word width.
- LEN_W, 24, header length field width; must be <= WORD_W-8.

Ports:
- clk  in  1  single system clock (PCIe bus clock domain).
- reset  in  1  asynchronous, active-high reset.
- rx_empty  in  1  rx FIFO empty; FIFO is show-ahead, so rx_q is valid whenever !rx_empty.
- rx_q  in  WORD_W  rx FIFO head word.
- rx_rdreq  out  1  pop rx FIFO.
- dst_full  in  NDEST  per-destination full.
- dst_wrreq  out  NDEST  per-destination write, one-hot or zero.
- dst_d  out  WORD_W  shared write data to all destinations.
- err_clear  in  1  clears sticky error flags.
- busy  out  1  packet in progress (state != IDLE).
- err_bad_dest  out  1  sticky: a header named dest >= NDEST.
- pkt_count  out  16  completed packets, wraps at 2^16.

Behaviour:
- Packet format: header word, then LEN payload words.
  - Header [31:24] = dest, [LEN_W-1:0] = LEN.
  - Bits between LEN_W and 23 are ignored.
- Reset (async, immediate):
  - state = IDLE; rx_rdreq = 0; dst_wrreq = 0; dst_d = 0; busy = 0; err flags = 0; pkt_count = 0; remaining count = 0.
- Reset mid-packet abandons the packet. Remaining rx words are then parsed as headers; recovery is the host's responsibility.
- States: IDLE, PAYLOAD, DRAIN, plus CHECK when the optional feature is enabled.
- IDLE:
  - If !rx_empty: rx_rdreq = 1 (header popped this cycle).
  - Latch dest and rem = LEN.
  - LEN == 0: stay IDLE, pkt_count += 1.
  - dest >= NDEST: go to DRAIN and set err_bad_dest.
  - Otherwise go to PAYLOAD.
- PAYLOAD:
  - rx_rdreq = !rx_empty && !dst_full[dest].
  - dst_wrreq[dest] = rx_rdreq; dst_d = rx_q. Both are combinational, so there is zero-cycle pass-through and no data is lost on full.
  - Each pop decrements rem.
  - On the pop with rem == 1: go to IDLE (or CHECK) and pkt_count += 1.
- DRAIN:
  - rx_rdreq = !rx_empty; no dst_wrreq; rem decrements per pop.
  - On the last pop: go to IDLE, pkt_count += 1 (or CHECK).
- Only one destination is ever written per cycle. dst_d for inactive destinations is don't-care; drive rx_q.
- Throughput: 1 word/cycle when data is available and not full. Header costs 1 cycle; back-to-back packets have no bubble beyond the header.
- pkt_count wraps 0xFFFF -> 0x0000.
- err_clear:
  - Clears sticky flags on the next clk edge.
  - A simultaneous set wins over clear.
- Width rules: rem is LEN_W bits; LEN up to 2^LEN_W-1 is legal.

Optional Feature:
- Macro: PCIE_RX_DISPATCH_CHECKSUM_EN.
- Defined:
  - Every packet (including LEN == 0) carries one trailer word after the payload.
  - XOR accumulator: cleared at header pop; XORs each popped payload word (also in DRAIN).
  - State CHECK: pop the trailer when !rx_empty and compare it to the accumulator.
  - Mismatch sets sticky output err_csum (extra 1-bit port) and pulses csum_bad for 1 cycle.
  - pkt_count increments at trailer pop, not at the last payload word.
  - Trailer is never forwarded.
- Undefined: no trailer, no CHECK state, no err_csum or csum_bad ports.

Decomposition:
- Shared package holds:
  - state enum (IDLE, PAYLOAD, DRAIN, CHECK);
  - header field offsets (DEST_LSB = 24, DEST_W = 8);
  - typedef for the header struct.
- No sub-module is needed.
- Optional sub-module pcie_rx_csum: XOR accumulator plus compare, instantiated only under the macro.

Test Plan:
- Header 0x01000003, then 0xA, 0xB, 0xC, no backpressure -> dst_wrreq[1] is asserted for 3 consecutive cycles with dst_d = A, B, C; pkt_count = 1; busy drops after the 3rd word.
- Same packet with dst_full[1] held high 5 cycles mid-packet -> no rx_rdreq during the stall; all 3 words delivered in order; no duplicates.
- Header 0x07000002 with NDEST = 4, then 2 words -> both words popped and no dst_wrreq; err_bad_dest = 1; next packet to dest 0 is delivered normally; err_clear then -> flag = 0.
- Header 0x02000000 followed immediately by header 0x00000001 and word 0x55 -> pkt_count goes 1 then 2; dst_wrreq[0] pulses once with 0x55; nothing is written to dest 2.
- Reset asserted while 2 of 4 payload words remain -> all outputs 0 asynchronously; state IDLE; pkt_count = 0.
- (CHECKSUM_EN) payload 0x0F and 0xF0, trailer 0xFF -> err_csum stays 0. Trailer 0xFE -> csum_bad pulses 1 cycle and err_csum = 1.
